// File: rtl/hazard_stall_controller.sv
//------------------------------------------------------------------------------
// hazard_stall_controller: IF/ID stall, flush and EX hold sequencing for the
// 5-stage pipeline (load-use, redirect, multi-cycle divide) with stall counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stall_controller #(
  parameter int MD_CYCLES = 33,
  parameter int CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_md_div,
  input  logic        ex_redirect,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_hold,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   md_cnt;
  logic               md_release;
  logic               load_use;
  logic               div_start;
  logic               cnt_load;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // The divide that just finished is still in EX during the release cycle.
  assign div_start = ex_md_div && !md_release;

  assign ctrl_state = state;

  // Outputs are forced to their idle values while reset is asserted so the
  // pipeline is released immediately, independent of the clock.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    cnt_load    = 1'b0;
    next_state  = state;
    if (rst_n) begin
      case (state)
        RUN, FLUSH: begin
          if (state == FLUSH) begin
            if_id_flush = 1'b1;
          end
          next_state = RUN;
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            next_state  = FLUSH;
          end else if (div_start) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            ex_hold    = 1'b1;
            cnt_load   = 1'b1;
            next_state = MD_BUSY;
          end else if (load_use && (state == RUN)) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          ex_hold    = 1'b1;
          next_state = (md_cnt == '0) ? RUN : MD_BUSY;
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      md_cnt      <= '0;
      md_release  <= 1'b0;
      stall_count <= 32'd0;
    end else begin
      state      <= next_state;
      md_release <= (state == MD_BUSY) && (md_cnt == '0);
      if (cnt_load) begin
        md_cnt <= CNT_W'(MD_CYCLES - 2);
      end else if ((state == MD_BUSY) && (md_cnt != '0)) begin
        md_cnt <= md_cnt - 1'b1;
      end
      if (!pc_en && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
`default_nettype none

module tb_hazard_stall_controller;
  localparam int MD = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_md_div, ex_redirect;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_count;

  hazard_stall_controller #(.MD_CYCLES(MD), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_md_div(ex_md_div), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_hold(ex_hold), .ctrl_state(ctrl_state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: cycles of divide hold still owed after the current one, a pending
  // second flush cycle, the one-cycle divide release, and the stall total.
  int          busy_left;
  bit          flush_next;
  bit          rel;
  logic [31:0] m_stall;
  logic        last_hold;
  logic [1:0]  last_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_left = 0; flush_next = 0; rel = 0; m_stall = 32'd0;
  endtask

  task automatic drive(input logic redir, input logic md, input logic mr, input logic [4:0] rd,
                       input logic u1, input logic [4:0] rs1, input logic u2, input logic [4:0] rs2);
    ex_redirect = redir; ex_md_div = md; ex_mem_read = mr; ex_rd = rd;
    id_use_rs1 = u1; id_rs1 = rs1; id_use_rs2 = u2; id_rs2 = rs2;
  endtask

  // One pipeline cycle: entered and left at posedge+1.
  task automatic step(input logic redir, input logic md, input logic mr, input logic [4:0] rd,
                      input logic u1, input logic [4:0] rs1, input logic u2, input logic [4:0] rs2);
    logic e_pc, e_ifen, e_iff, e_idf, e_hold, lu;
    logic [1:0] e_st;
    drive(redir, md, mr, rd, u1, rs1, u2, rs2);
    lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e_pc = 1; e_ifen = 1; e_iff = 0; e_idf = 0; e_hold = 0;
    if (busy_left > 0) begin
      e_pc = 0; e_ifen = 0; e_hold = 1; e_st = 2'd1;
    end else begin
      e_st  = flush_next ? 2'd2 : 2'd0;
      e_iff = flush_next;
      if (redir) begin
        e_iff = 1; e_idf = 1;
      end else if (md && !rel) begin
        e_pc = 0; e_ifen = 0; e_hold = 1;
      end else if (lu && !flush_next) begin
        e_pc = 0; e_ifen = 0; e_idf = 1;
      end
    end
    #3;
    chk("pc_en", pc_en, e_pc);
    chk("if_id_en", if_id_en, e_ifen);
    chk("if_id_flush", if_id_flush, e_iff);
    chk("id_ex_flush", id_ex_flush, e_idf);
    chk("ex_hold", ex_hold, e_hold);
    chk("ctrl_state", ctrl_state, e_st);
    chk("stall_count", stall_count, m_stall);
    last_hold = ex_hold; last_st = ctrl_state;
    if (busy_left > 0) begin
      rel = (busy_left == 1); busy_left--; flush_next = 0;
    end else begin
      busy_left  = (!redir && md && !rel) ? MD - 1 : 0;
      flush_next = redir;
      rel = 0;
    end
    if (!e_pc && m_stall != 32'hFFFF_FFFF) m_stall++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int hold_cnt, busy_cnt;
    logic [31:0] s0;
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_state", ctrl_state, 2'd0);
    chk("rst_pc_en", pc_en, 1'b1);
    chk("rst_stall", stall_count, 32'd0);
    rst_n = 1;
    idle(2);

    // Load-use on rs2, then the same pattern with x0 as destination.
    s0 = m_stall;
    step(0, 0, 1, 5'd5, 0, 5'd0, 1, 5'd5);
    step(0, 0, 0, 5'd5, 0, 5'd0, 1, 5'd5);
    chk("lu_stall_inc", stall_count, s0 + 32'd1);
    step(0, 0, 1, 5'd0, 0, 5'd0, 1, 5'd0);
    chk("lu_x0_no_stall", stall_count, s0 + 32'd1);

    // Divide held until after release, then a back-to-back divide.
    s0 = m_stall; hold_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < MD + 1; i++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      hold_cnt += int'(last_hold);
      busy_cnt += int'(last_st == 2'd1);
    end
    chk("div_hold_cycles", hold_cnt, MD);
    chk("div_busy_cycles", busy_cnt, MD - 1);
    chk("div_stall", stall_count, s0 + MD);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("div_b2b_hold", last_hold, 1'b1);
    // Redirect and load-use arriving mid-divide are ignored.
    step(1, 0, 1, 5'd3, 1, 5'd3, 0, 0);
    idle(MD);

    // Single and back-to-back redirects.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Everything at once in RUN: flush wins.
    step(1, 1, 1, 5'd7, 1, 5'd7, 1, 5'd7);
    step(0, 0, 1, 5'd7, 1, 5'd7, 0, 0);
    idle(2);

    // Saturation of the stall counter.
    force dut.stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5'd9, 1, 5'd9, 0, 0);
    idle(2);
    chk("sat_hold", stall_count, 32'hFFFF_FFFF);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a divide.
    idle(2);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_state", ctrl_state, 2'd0);
    chk("arst_hold", ex_hold, 1'b0);
    chk("arst_pc_en", pc_en, 1'b1);
    chk("arst_stall", stall_count, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequences the fetch/decode boundary of the 5-stage RV32IM pipeline. It generates the PC enable, IF/ID enable and flush, ID/EX bubble and EX hold controls from load-use hazards, taken-branch/jump redirects and multi-cycle divide operations. The instruction word reaching decode comes from the synchronous instruction memory, so redirects take two flush cycles at the IF/ID boundary. The block also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- MD_CYCLES, 33, total EX hold cycles for a divide/remainder instruction (legal range 2..63)
- CNT_W, 6, width of the internal divide countdown counter
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_rs1  input  5  source register 1 of the instruction in ID
- id_rs2  input  5  source register 2 of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  5  destination register of the instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- ex_md_div  input  1  EX instruction is DIV/DIVU/REM/REMU
- ex_redirect  input  1  EX resolved a taken branch or jump
- pc_en  output  1  PC register update enable; also gates the imem address
- if_id_en  output  1  IF/ID register update enable
- if_id_flush  output  1  IF/ID contents replaced by NOP
- id_ex_flush  output  1  ID/EX contents replaced by bubble
- ex_hold  output  1  EX stage and EX/MEM hold
- ctrl_state  output  2  0=RUN, 1=MD_BUSY, 2=FLUSH
- stall_count  output  32  count of cycles with pc_en=0, saturating

## Operation
- The state machine has three states: RUN, MD_BUSY and FLUSH. A 1-bit md_release register and a CNT_W countdown counter are also kept.
- Load-use hazard condition: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- In RUN, events are handled in priority order; first match wins, and outputs are combinational in the same cycle.
  - ex_redirect: if_id_flush=1 and id_ex_flush=1. Next state is FLUSH.
  - ex_md_div && !md_release: pc_en=0, if_id_en=0 and ex_hold=1. The counter is loaded with MD_CYCLES-2. Next state is MD_BUSY.
  - Load-use: pc_en=0, if_id_en=0 and id_ex_flush=1. State stays RUN; this is a single-cycle bubble.
  - Otherwise: pc_en=1, if_id_en=1, and all flushes and hold are 0.
- In MD_BUSY:
  - Outputs are pc_en=0, if_id_en=0 and ex_hold=1.
  - ex_redirect and load-use are ignored.
  - If the counter is 0, the next state is RUN and md_release is set. Otherwise the counter decrements.
- md_release is set only on the MD_BUSY to RUN transition and clears after one cycle. While it is set, ex_md_div is ignored so the same divide advances out of EX.
- In FLUSH:
  - if_id_flush=1 to kill the wrong-path word from the synchronous imem. pc_en=1.
  - Load-use is ignored because ID holds a bubble.
  - ex_redirect is handled as in RUN: it re-enters FLUSH and also asserts id_ex_flush.
  - ex_md_div is handled as in RUN.
  - Otherwise, the next state is RUN.
- stall_count increments on every clock edge where pc_en=0. It holds at 32'hFFFFFFFF.

## Timing
- Reset values (applied immediately on rst_n low, independent of clk):
  - ctrl_state=RUN, counter=0, md_release=0, stall_count=0.
  - Outputs settle to pc_en=1, if_id_en=1, if_id_flush=0, id_ex_flush=0, ex_hold=0.
- Reset mid-divide or mid-flush abandons the operation. There is no replay.
- A divide seen in RUN at cycle T holds the pipeline for exactly MD_CYCLES cycles (T..T+MD_CYCLES-1). Cycle T+MD_CYCLES is the release cycle, where ex_hold=0 and pc_en=1 unless another event applies. MD_BUSY lasts MD_CYCLES-1 cycles.
- A redirect at cycle T asserts if_id_flush for cycles T and T+1 and id_ex_flush for cycle T only.
- A load-use hazard costs exactly 1 cycle. The load moves to MEM at the next edge, so the condition clears by itself.
- A load-use hazard coincident with a redirect produces the flush only, with pc_en=1.
- A divide immediately after release, with a new ex_md_div in the cycle after release, starts a new hold.

## Test plan
- Reset: drive rst_n=0 mid-MD_BUSY -> ctrl_state=0, ex_hold=0, pc_en=1 and stall_count=0 immediately, without waiting for a clock edge.
- Load-use: ex_mem_read=1, ex_rd=5, id_use_rs2=1, id_rs2=5 for one cycle -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, and stall_count increments by 1. Repeat with ex_rd=0 -> no stall.
- Divide with MD_CYCLES=33: ex_md_div held high from cycle T until release -> ex_hold=1 for 33 consecutive cycles, ctrl_state=1 for 32 of them, then one release cycle with ex_hold=0, and stall_count=33.
- Redirect: pulse ex_redirect at T -> if_id_flush=1 at T and T+1, id_ex_flush=1 only at T, and ctrl_state=2 at T+1. A second redirect at T+1 -> flush extends to T+2.
- Priority: ex_redirect, ex_md_div and a load-use hazard together in RUN -> flush only, ctrl_state goes to FLUSH, and ex_hold=0. A redirect or load-use during MD_BUSY -> ignored.
- Saturation: preload stall_count to 32'hFFFFFFFE (force) and apply 3 stall cycles -> value reads 32'hFFFFFFFF and stays there.
